my_fft_ctrl: RTL and testbench
==============================

# my_fft_ctrl

Run-level sequencer for the variable-streaming FFT core. Accepts an unframed complex sample stream from upstream and feeds it to the core's sink port in frames of exactly cfg_pts samples, with sop/eop, fftpts and inverse generated here. Counts and checks the frames leaving the core's source port and reports run completion and errors. Manages the core's own active-low reset on abort. Sits between the sample capture buffer and the FFT core instance.

## Interface
- DATA_W, 14: sample component width, matching the core sink_real/sink_imag.
- PTS_W, 11: width of the fftpts field.
- MAX_PTS, 1024: largest legal transform size.
- FRM_W, 8: width of the frame-count field.

- clk, in, 1: the single clock.
- reset, in, 1: asynchronous, active-high.
- start, in, 1: single-cycle pulse that launches a run; ignored unless the state is IDLE.
- abort, in, 1: takes priority over everything else; forces FLUSH.
- cfg_pts, in, PTS_W: transform size; latched when start is accepted.
- cfg_inverse, in, 1: latched when start is accepted.
- cfg_frames, in, FRM_W: number of frames in the run (1..255); latched when start is accepted.
- in_valid / in_ready, in / out, 1 / 1: upstream sample handshake.
- in_real / in_imag, in, DATA_W each: upstream sample.
- fft_reset_n, out, 1: active-low reset to the core.
- fft_sink_valid / fft_sink_ready, out / in, 1 / 1: core sink handshake.
- fft_sink_sop / fft_sink_eop, out, 1 each: frame markers.
- fft_sink_real / fft_sink_imag, out, DATA_W each: sample to the core.
- fft_sink_error, out, 2: constant 0.
- fft_fftpts, out, PTS_W: latched cfg_pts.
- fft_inverse, out, 1: latched cfg_inverse.
- fft_source_valid / fft_source_sop / fft_source_eop, in, 1 each: core output stream monitors.
- fft_source_error, in, 2: core output error field.
- fft_source_ready, out, 1: equals out_ready.
- out_ready, in, 1: downstream consumer ready.
- busy, out, 1: asserted in RUN and DRAIN.
- done, out, 1: one-cycle pulse at run completion.
- err, out, 1: sticky error flag.
- err_code, out, 3: bit0 = illegal config, bit1 = output framing error, bit2 = core source_error nonzero.

## Operation
- **States:** FLUSH, IDLE, RUN, DRAIN. reset enters FLUSH asynchronously.
- **FLUSH:**
  - fft_reset_n = 0 for 4 cycles, then → IDLE.
  - abort in any state → FLUSH, restarting the 4-cycle count.
  - Clears all counters.
  - err and err_code are not cleared by abort; they clear only on reset or on an accepted start.
- **IDLE:**
  - On start, cfg_pts must be a power of two in 8..MAX_PTS, and cfg_frames must be ≠ 0.
  - If both hold: latch the config, clear err, → RUN.
  - Otherwise: stay in IDLE, set err and err_code bit0.
- **RUN:**
  - fft_sink_valid = in_valid. in_ready = fft_sink_ready. Data passes through combinationally (zero latency).
  - A transfer is a cycle with valid & ready.
  - in_idx counts transfers from 0 to pts-1 and wraps. fft_sink_sop = (in_idx == 0). fft_sink_eop = (in_idx == pts-1).
  - in_frm increments on each eop transfer. The eop transfer of frame cfg_frames-1 → DRAIN.
- **DRAIN:**
  - fft_sink_valid = 0 and in_ready = 0.
  - When out_frm == cfg_frames → IDLE and pulse done.
- **Output monitor:** active in RUN and DRAIN.
  - A source transfer is fft_source_valid & out_ready.
  - out_idx counts transfers modulo pts.
  - sop must coincide with out_idx == 0 and eop with out_idx == pts-1. Any mismatch sets err_code bit1.
  - out_frm increments on each eop transfer.
  - fft_source_error ≠ 0 on any transfer sets err_code bit2.
  - err = OR of err_code.
- **Outside RUN:** fft_sink_valid and in_ready are 0.
- **Counter widths:** in_idx and out_idx are PTS_W bits; in_frm and out_frm are FRM_W bits.

## Timing
- **Reset values:**
  - fft_reset_n 0, busy 0, done 0, err 0, err_code 0.
  - fft_sink_valid 0, in_ready 0, sop 0, eop 0.
  - fft_fftpts = MAX_PTS, fft_inverse 0.
- **Start:** start accepted in cycle N → busy = 1 and sink valid enabled from cycle N+1.
- **Done:** the final source eop transfer in cycle M → done is high in cycle M+1, together with busy falling.
- **Overlap:** out_frm can reach cfg_frames while still in RUN only if the core misbehaves. out_frm is checked only in DRAIN; extra output frames set bit1.
- **Sink stall:** fft_sink_ready low holds in_idx. sop/eop stay valid for the held sample.
- **Abort timing:** abort in the same cycle as start → abort wins. abort during a transfer cycle → the transfer is not counted.
- **Config ports:** fft_fftpts and fft_inverse change only in the cycle after an accepted start. They are stable for the whole run.

## Structure
- **Shared package my_fft_pkg:**
  - state enum
  - err_code bit indices
  - FLUSH_CYCLES = 4
  - pts legality function (power of two, range check)
- **Sub-module my_fft_frame_mon:** the output monitor (out_idx, out_frm, framing and error checks). It is reused on other core instances.

## Test plan
- **Single frame:** cfg_pts=64, cfg_frames=1, continuous valid/ready.
  - sop on sample 0 and eop on sample 63.
  - Model core returns 64 samples → done 1 cycle after the output eop, err = 0.
- **Backpressure:** cfg_pts=8, cfg_frames=3, fft_sink_ready toggling 1/0.
  - Exactly 24 transfers; sop on samples 0, 8 and 16; eop on samples 7, 15 and 23.
  - No transfer counted while ready = 0.
- **Illegal config:** start with cfg_pts=100, then again with cfg_frames=0.
  - State stays IDLE, err_code = 3'b001, busy stays 0.
  - A later legal start clears err.
- **Framing fault:** model core asserts eop at out_idx 30 with pts=32 → err_code bit1 set and held through done.
- **Abort mid-run:** abort at in_idx 17 of frame 1.
  - fft_reset_n low for exactly 4 cycles; then IDLE with busy = 0.
  - in_ready = 0 throughout; err unchanged.
- **Reset mid-DRAIN:** assert reset asynchronously.
  - All outputs go to their reset values immediately.
  - FLUSH lasts 4 cycles, then IDLE.

Source files
------------

// File: rtl/my_fft_pkg.sv
// Shared types, error-bit indices and config helpers for the FFT run sequencer
// and its output frame monitor.
package my_fft_pkg;

  typedef enum logic [1:0] {
    ST_FLUSH = 2'd0,
    ST_IDLE  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam int ERR_CFG   = 0;
  localparam int ERR_FRAME = 1;
  localparam int ERR_SRC   = 2;

  localparam int FLUSH_CYCLES = 4;

  // Legal transform sizes are powers of two from 8 up to max_pts.
  function automatic logic pts_legal(input logic [31:0] pts, input logic [31:0] max_pts);
    logic [31:0] pm1;
    pm1 = pts - 32'd1;
    return (pts >= 32'd8) && (pts <= max_pts) && ((pts & pm1) == 32'd0);
  endfunction

endpackage

// File: rtl/my_fft_frame_mon.sv
// Output-stream monitor for an FFT core source port: tracks sample index and
// frame count, and flags framing or core-reported errors on each transfer.
module my_fft_frame_mon
  import my_fft_pkg::*;
#(
  parameter int PTS_W = 11,
  parameter int FRM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             active,
  input  logic [PTS_W-1:0] pts,
  input  logic [FRM_W-1:0] frames,
  input  logic             src_valid,
  input  logic             src_sop,
  input  logic             src_eop,
  input  logic [1:0]       src_error,
  input  logic             out_ready,
  output logic [FRM_W-1:0] out_frm_next,
  output logic             frame_err,
  output logic             src_err
);

  logic [PTS_W-1:0] out_idx;
  logic [PTS_W-1:0] out_idx_next;
  logic [FRM_W-1:0] out_frm;
  logic             xfer;
  logic             at_first;
  logic             at_last;

  // Transfer decode, framing expectations and next counter values.
  always_comb begin
    xfer         = active & src_valid & out_ready;
    at_first     = (out_idx == {PTS_W{1'b0}});
    at_last      = (out_idx == (pts - PTS_W'(1)));
    out_idx_next = out_idx;
    out_frm_next = out_frm;
    frame_err    = 1'b0;
    src_err      = 1'b0;
    if (xfer) begin
      if (at_last) begin
        out_idx_next = {PTS_W{1'b0}};
      end else begin
        out_idx_next = out_idx + PTS_W'(1);
      end
      if (src_eop) begin
        out_frm_next = out_frm + FRM_W'(1);
      end else begin
        out_frm_next = out_frm;
      end
      // An eop beyond the configured frame count is also a framing fault.
      frame_err = (src_sop != at_first) || (src_eop != at_last) ||
                  (src_eop && (out_frm >= frames));
      src_err   = (src_error != 2'b00);
    end else begin
      out_idx_next = out_idx;
      out_frm_next = out_frm;
    end
  end

  // Counters run only while the sequencer is busy; cleared otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_idx <= {PTS_W{1'b0}};
      out_frm <= {FRM_W{1'b0}};
    end else if (!active) begin
      out_idx <= {PTS_W{1'b0}};
      out_frm <= {FRM_W{1'b0}};
    end else begin
      out_idx <= out_idx_next;
      out_frm <= out_frm_next;
    end
  end

endmodule

// File: rtl/my_fft_ctrl.sv
// Run-level sequencer for the streaming FFT core: frames the input stream,
// drives core config and reset, and checks the returning frames.
module my_fft_ctrl
  import my_fft_pkg::*;
#(
  parameter int DATA_W  = 14,
  parameter int PTS_W   = 11,
  parameter int MAX_PTS = 1024,
  parameter int FRM_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [PTS_W-1:0]  cfg_pts,
  input  logic              cfg_inverse,
  input  logic [FRM_W-1:0]  cfg_frames,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_real,
  input  logic [DATA_W-1:0] in_imag,
  output logic              fft_reset_n,
  output logic              fft_sink_valid,
  input  logic              fft_sink_ready,
  output logic              fft_sink_sop,
  output logic              fft_sink_eop,
  output logic [DATA_W-1:0] fft_sink_real,
  output logic [DATA_W-1:0] fft_sink_imag,
  output logic [1:0]        fft_sink_error,
  output logic [PTS_W-1:0]  fft_fftpts,
  output logic              fft_inverse,
  input  logic              fft_source_valid,
  input  logic              fft_source_sop,
  input  logic              fft_source_eop,
  input  logic [1:0]        fft_source_error,
  output logic              fft_source_ready,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        err_code
);

  state_t           state;
  state_t           state_next;
  logic [2:0]       flush_cnt;
  logic [PTS_W-1:0] pts;
  logic             inverse;
  logic [FRM_W-1:0] frames;
  logic [PTS_W-1:0] in_idx;
  logic [FRM_W-1:0] in_frm;
  logic [FRM_W-1:0] out_frm_next;
  logic             frame_err;
  logic             src_err;
  logic             run_live;
  logic             in_xfer;
  logic             last_in;
  logic             last_frm;
  logic             start_ok;
  logic             cfg_ok;
  logic             drain_done;
  logic [2:0]       err_set;

  // Control decode shared by next-state, counters and outputs.
  always_comb begin
    // Abort suppresses the handshake so an aborted transfer never counts.
    run_live   = (state == ST_RUN) && !abort;
    in_xfer    = run_live && in_valid && fft_sink_ready;
    last_in    = (in_idx == (pts - PTS_W'(1)));
    last_frm   = (in_frm == (frames - FRM_W'(1)));
    start_ok   = (state == ST_IDLE) && start && !abort;
    cfg_ok     = pts_legal(32'(cfg_pts), 32'(MAX_PTS)) && (cfg_frames != {FRM_W{1'b0}});
    drain_done = (state == ST_DRAIN) && !abort && (out_frm_next == frames);
    err_set             = 3'b000;
    err_set[ERR_CFG]    = start_ok && !cfg_ok;
    err_set[ERR_FRAME]  = frame_err;
    err_set[ERR_SRC]    = src_err;
  end

  // Next-state logic; abort overrides every state.
  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = ST_FLUSH;
    end else begin
      case (state)
        ST_FLUSH: begin
          if (flush_cnt == 3'(FLUSH_CYCLES - 1)) begin
            state_next = ST_IDLE;
          end else begin
            state_next = ST_FLUSH;
          end
        end
        ST_IDLE: begin
          if (start_ok && cfg_ok) begin
            state_next = ST_RUN;
          end else begin
            state_next = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (in_xfer && last_in && last_frm) begin
            state_next = ST_DRAIN;
          end else begin
            state_next = ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (drain_done) begin
            state_next = ST_IDLE;
          end else begin
            state_next = ST_DRAIN;
          end
        end
        default: state_next = ST_FLUSH;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_FLUSH;
    end else begin
      state <= state_next;
    end
  end

  // Core reset hold counter; restarts on every abort.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flush_cnt <= 3'd0;
    end else if (abort || (state != ST_FLUSH)) begin
      flush_cnt <= 3'd0;
    end else begin
      flush_cnt <= flush_cnt + 3'd1;
    end
  end

  // Run configuration, captured only on a legal start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pts     <= PTS_W'(MAX_PTS);
      inverse <= 1'b0;
      frames  <= FRM_W'(1);
    end else if (start_ok && cfg_ok) begin
      pts     <= cfg_pts;
      inverse <= cfg_inverse;
      frames  <= cfg_frames;
    end else begin
      pts     <= pts;
      inverse <= inverse;
      frames  <= frames;
    end
  end

  // Input sample index and frame counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_idx <= {PTS_W{1'b0}};
      in_frm <= {FRM_W{1'b0}};
    end else if (state != ST_RUN) begin
      in_idx <= {PTS_W{1'b0}};
      in_frm <= {FRM_W{1'b0}};
    end else if (in_xfer) begin
      if (last_in) begin
        in_idx <= {PTS_W{1'b0}};
        in_frm <= in_frm + FRM_W'(1);
      end else begin
        in_idx <= in_idx + PTS_W'(1);
        in_frm <= in_frm;
      end
    end else begin
      in_idx <= in_idx;
      in_frm <= in_frm;
    end
  end

  // Sticky error code, cleared only by reset or a legal start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_code <= 3'b000;
    end else if (start_ok && cfg_ok) begin
      err_code <= 3'b000;
    end else begin
      err_code <= err_code | err_set;
    end
  end

  // Completion pulse, aligned with the return to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done <= 1'b0;
    end else begin
      done <= drain_done;
    end
  end

  my_fft_frame_mon #(
    .PTS_W (PTS_W),
    .FRM_W (FRM_W)
  ) u_frame_mon (
    .clk          (clk),
    .rst          (reset),
    .active       (busy),
    .pts          (pts),
    .frames       (frames),
    .src_valid    (fft_source_valid),
    .src_sop      (fft_source_sop),
    .src_eop      (fft_source_eop),
    .src_error    (fft_source_error),
    .out_ready    (out_ready),
    .out_frm_next (out_frm_next),
    .frame_err    (frame_err),
    .src_err      (src_err)
  );

  // Output drive; sink data is a zero-latency pass-through.
  always_comb begin
    busy             = (state == ST_RUN) || (state == ST_DRAIN);
    fft_reset_n      = (state != ST_FLUSH);
    fft_sink_valid   = run_live && in_valid;
    in_ready         = run_live && fft_sink_ready;
    fft_sink_sop     = (state == ST_RUN) && (in_idx == {PTS_W{1'b0}});
    fft_sink_eop     = (state == ST_RUN) && last_in;
    fft_sink_real    = in_real;
    fft_sink_imag    = in_imag;
    fft_sink_error   = 2'b00;
    fft_fftpts       = pts;
    fft_inverse      = inverse;
    fft_source_ready = out_ready;
    err              = |err_code;
  end

endmodule

// File: tb/tb_my_fft_ctrl.sv
// Directed self-checking bench for my_fft_ctrl; the core is modelled by
// driving its source-port signals from bench tasks.
module tb_my_fft_ctrl;

  localparam int DATA_W = 14;
  localparam int PTS_W  = 11;
  localparam int FRM_W  = 8;

  logic              clk = 1'b0;
  logic              reset, start, abort, cfg_inverse;
  logic [PTS_W-1:0]  cfg_pts;
  logic [FRM_W-1:0]  cfg_frames;
  logic              in_valid, in_ready;
  logic [DATA_W-1:0] in_real, in_imag;
  logic              fft_reset_n, fft_sink_valid, fft_sink_ready;
  logic              fft_sink_sop, fft_sink_eop;
  logic [DATA_W-1:0] fft_sink_real, fft_sink_imag;
  logic [1:0]        fft_sink_error;
  logic [PTS_W-1:0]  fft_fftpts;
  logic              fft_inverse;
  logic              fft_source_valid, fft_source_sop, fft_source_eop;
  logic [1:0]        fft_source_error;
  logic              fft_source_ready, out_ready;
  logic              busy, done, err;
  logic [2:0]        err_code;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  my_fft_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_pts(cfg_pts), .cfg_inverse(cfg_inverse), .cfg_frames(cfg_frames),
    .in_valid(in_valid), .in_ready(in_ready), .in_real(in_real), .in_imag(in_imag),
    .fft_reset_n(fft_reset_n), .fft_sink_valid(fft_sink_valid),
    .fft_sink_ready(fft_sink_ready), .fft_sink_sop(fft_sink_sop),
    .fft_sink_eop(fft_sink_eop), .fft_sink_real(fft_sink_real),
    .fft_sink_imag(fft_sink_imag), .fft_sink_error(fft_sink_error),
    .fft_fftpts(fft_fftpts), .fft_inverse(fft_inverse),
    .fft_source_valid(fft_source_valid), .fft_source_sop(fft_source_sop),
    .fft_source_eop(fft_source_eop), .fft_source_error(fft_source_error),
    .fft_source_ready(fft_source_ready), .out_ready(out_ready),
    .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int pts, input int frames, input bit inv);
    start       = 1'b1;
    cfg_pts     = pts[PTS_W-1:0];
    cfg_frames  = frames[FRM_W-1:0];
    cfg_inverse = inv;
    step();
    start = 1'b0;
    #1;
  endtask

  // Push n samples upstream; counts sample-level deviations from the framing model.
  task automatic feed(input int n, input int pts, input bit toggle,
                      output int xfers, output int bad);
    int cyc;
    bit r;
    xfers = 0;
    bad   = 0;
    cyc   = 0;
    while (xfers < n && cyc < 1000) begin
      r              = toggle ? (cyc % 2 == 0) : 1'b1;
      fft_sink_ready = r;
      in_valid       = 1'b1;
      in_real        = DATA_W'(xfers);
      in_imag        = DATA_W'(xfers + 100);
      #1;
      if (fft_sink_valid !== 1'b1 || in_ready !== r ||
          fft_sink_sop !== (xfers % pts == 0) || fft_sink_eop !== (xfers % pts == pts - 1) ||
          fft_sink_real !== in_real || fft_sink_imag !== in_imag)
        bad++;
      if (r) xfers++;
      cyc++;
      step();
    end
    in_valid = 1'b0;
  endtask

  // Model the core's output stream until done is seen (or budget expires).
  task automatic drain(input int pts, input int eop_pos, input int last_k, input bit toggle,
                       output int gap, output int busy_at_done, output int done_after,
                       output int mism);
    int k, cyc, last, dc;
    bit r;
    k = 0; cyc = 0; last = -1000; dc = -1; mism = 0; busy_at_done = 1;
    while (dc < 0 && cyc < 400) begin
      r                = toggle ? (cyc % 2 == 0) : 1'b1;
      out_ready        = r;
      fft_source_valid = 1'b1;
      fft_source_sop   = (k % pts == 0);
      fft_source_eop   = (k % pts == eop_pos);
      #1;
      if (fft_source_ready !== r) mism++;
      if (done === 1'b1) begin
        dc = cyc;
        busy_at_done = int'(busy);
      end else if (r) begin
        if (k == last_k) last = cyc;
        k++;
      end
      cyc++;
      step();
    end
    fft_source_valid = 1'b0;
    fft_source_sop   = 1'b0;
    fft_source_eop   = 1'b0;
    #1;
    done_after = int'(done);
    gap        = dc - last;
  endtask

  // Count consecutive cycles with the core held in reset, checking the handshake stays closed.
  task automatic measure_flush(output int n, output int bad);
    n   = 0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (fft_reset_n !== 1'b0) break;
      n++;
      if (in_ready !== 1'b0 || busy !== 1'b0) bad++;
      step();
    end
  endtask

  int n, bad, x, gap, bz, da, mm;

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; cfg_inverse = 1'b0;
    cfg_pts = '0; cfg_frames = '0; in_valid = 1'b0; in_real = '0; in_imag = '0;
    fft_sink_ready = 1'b0; fft_source_valid = 1'b0; fft_source_sop = 1'b0;
    fft_source_eop = 1'b0; fft_source_error = 2'b00; out_ready = 1'b0;
    #2;
    check("rst_fft_reset_n", 32'(fft_reset_n), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_sink_valid", 32'(fft_sink_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_sop_eop", 32'({fft_sink_sop, fft_sink_eop}), 32'd0);
    check("rst_fftpts", 32'(fft_fftpts), 32'd1024);
    check("rst_inverse", 32'(fft_inverse), 32'd0);
    check("rst_sink_error", 32'(fft_sink_error), 32'd0);
    #1 reset = 1'b0;
    measure_flush(n, bad);
    check("init_flush_len", 32'(n), 32'd4);
    check("init_idle_busy", 32'(busy), 32'd0);

    // Single frame, continuous flow.
    do_start(64, 1, 1'b1);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_fftpts", 32'(fft_fftpts), 32'd64);
    check("t1_inverse", 32'(fft_inverse), 32'd1);
    feed(64, 64, 1'b0, x, bad);
    check("t1_xfers", 32'(x), 32'd64);
    check("t1_sink_frame", 32'(bad), 32'd0);
    in_valid = 1'b1; fft_sink_ready = 1'b1; #1;
    check("t1_drain_valid", 32'(fft_sink_valid), 32'd0);
    check("t1_drain_ready", 32'(in_ready), 32'd0);
    check("t1_drain_busy", 32'(busy), 32'd1);
    in_valid = 1'b0;
    drain(64, 63, 63, 1'b0, gap, bz, da, mm);
    check("t1_done_gap", 32'(gap), 32'd1);
    check("t1_busy_at_done", 32'(bz), 32'd0);
    check("t1_done_pulse", 32'(da), 32'd0);
    check("t1_src_ready", 32'(mm), 32'd0);
    check("t1_err", 32'(err), 32'd0);

    // Backpressure on both sides.
    do_start(8, 3, 1'b0);
    feed(24, 8, 1'b1, x, bad);
    check("t2_xfers", 32'(x), 32'd24);
    check("t2_sink_frame", 32'(bad), 32'd0);
    in_valid = 1'b1; #1;
    check("t2_drain_valid", 32'(fft_sink_valid), 32'd0);
    in_valid = 1'b0;
    drain(8, 7, 23, 1'b1, gap, bz, da, mm);
    check("t2_done_gap", 32'(gap), 32'd1);
    check("t2_busy_at_done", 32'(bz), 32'd0);
    check("t2_src_ready", 32'(mm), 32'd0);
    check("t2_err", 32'(err), 32'd0);

    // Illegal configurations, then a legal start clears the error.
    do_start(100, 1, 1'b0);
    check("t3_pts_busy", 32'(busy), 32'd0);
    check("t3_pts_code", 32'(err_code), 32'd1);
    check("t3_pts_fftpts", 32'(fft_fftpts), 32'd8);
    do_start(64, 0, 1'b0);
    check("t3_frm_busy", 32'(busy), 32'd0);
    check("t3_frm_code", 32'(err_code), 32'd1);
    check("t3_frm_err", 32'(err), 32'd1);
    do_start(32, 1, 1'b0);
    check("t3_legal_err", 32'(err), 32'd0);
    check("t3_legal_busy", 32'(busy), 32'd1);

    // Framing fault: core raises eop at index 30 of a 32-point frame.
    feed(32, 32, 1'b0, x, bad);
    check("t4_xfers", 32'(x), 32'd32);
    drain(32, 30, 30, 1'b0, gap, bz, da, mm);
    check("t4_done_gap", 32'(gap), 32'd1);
    check("t4_err_code", 32'(err_code), 32'd2);
    step();
    step();
    check("t4_err_held", 32'(err_code), 32'd2);

    // Abort mid-run; a core source error beforehand must survive the abort.
    do_start(32, 2, 1'b0);
    check("t5_err_cleared", 32'(err), 32'd0);
    fft_source_valid = 1'b1; fft_source_sop = 1'b1; fft_source_error = 2'b01; out_ready = 1'b1;
    step();
    fft_source_valid = 1'b0; fft_source_sop = 1'b0; fft_source_error = 2'b00;
    #1;
    check("t5_src_err", 32'(err_code), 32'd4);
    feed(49, 32, 1'b0, x, bad);
    check("t5_sink_frame", 32'(bad), 32'd0);
    abort = 1'b1; in_valid = 1'b1; fft_sink_ready = 1'b1;
    #1;
    step();
    abort = 1'b0;
    measure_flush(n, bad);
    check("t5_flush_len", 32'(n), 32'd4);
    check("t5_flush_closed", 32'(bad), 32'd0);
    check("t5_idle_busy", 32'(busy), 32'd0);
    check("t5_idle_ready", 32'(in_ready), 32'd0);
    check("t5_err_kept", 32'(err_code), 32'd4);
    in_valid = 1'b0;

    // Asynchronous reset while draining.
    do_start(8, 1, 1'b1);
    feed(8, 8, 1'b0, x, bad);
    #1;
    check("t6_drain_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("t6_rst_fft_reset_n", 32'(fft_reset_n), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_fftpts", 32'(fft_fftpts), 32'd1024);
    check("t6_rst_inverse", 32'(fft_inverse), 32'd0);
    check("t6_rst_err_code", 32'(err_code), 32'd0);
    #1 reset = 1'b0;
    measure_flush(n, bad);
    check("t6_flush_len", 32'(n), 32'd4);
    check("t6_idle", 32'({fft_reset_n, busy}), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
